// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - Shared widths, request record and FSM states for dual_port_dmem
package dmem_pkg;

   localparam int WORD_W    = 64;
   localparam int NUM_BANKS = 2;

   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic              we;
      logic              re;
   } req_t;

   typedef enum logic {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - Two-slot load/store port bundle between the LEGv8 core and dual_port_dmem
interface dmem_if;

   logic [63:0] mem_address1;
   logic [63:0] mem_address2;
   logic [63:0] mem_data_in1;
   logic [63:0] mem_data_in2;
   logic        control_memwrite1;
   logic        control_memwrite2;
   logic        control_memread1;
   logic        control_memread2;
   logic [63:0] mem_data_out1;
   logic [63:0] mem_data_out2;
   logic        mem_rvalid1;
   logic        mem_rvalid2;
   logic        mem_stall;
   logic [15:0] conflict_cnt;

   modport master (
      output mem_address1, mem_address2, mem_data_in1, mem_data_in2,
      output control_memwrite1, control_memwrite2, control_memread1, control_memread2,
      input  mem_data_out1, mem_data_out2, mem_rvalid1, mem_rvalid2, mem_stall, conflict_cnt
   );

   modport slave (
      input  mem_address1, mem_address2, mem_data_in1, mem_data_in2,
      input  control_memwrite1, control_memwrite2, control_memread1, control_memread2,
      output mem_data_out1, mem_data_out2, mem_rvalid1, mem_rvalid2, mem_stall, conflict_cnt
   );

endinterface

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - Single-port synchronous RAM bank with registered read data
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int ROWS = 128
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [$clog2(ROWS)-1:0] row,
   input  logic [WORD_W-1:0]       wdata,
   output logic [WORD_W-1:0]       rdata
);

   logic [WORD_W-1:0] mem [ROWS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[row] <= wdata;
         end else begin
            rdata <= mem[row];
         end
      end
   end

endmodule

// File: rtl/dual_port_dmem.sv
// rtl/dual_port_dmem.sv - Two-slot, two-bank 64-bit data memory with same-bank replay
// Optional store-to-load forwarding between slots is enabled by defining DMEM_FWD_EN.
module dual_port_dmem
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input logic   CLOCK,
   input logic   RESET,
   dmem_if.slave bus
);

   localparam int AW   = $clog2(DEPTH_WORDS);
   localparam int RW   = AW - 1;
   localparam int ROWS = DEPTH_WORDS / NUM_BANKS;

   function automatic logic bank_of(input logic [WORD_W-1:0] a);
      return a[3];
   endfunction

   function automatic logic [RW-1:0] row_of(input logic [WORD_W-1:0] a);
      return a[4 +: RW];
   endfunction

   function automatic logic [AW-1:0] word_of(input logic [WORD_W-1:0] a);
      return a[3 +: AW];
   endfunction

   req_t   req1, req2, rep_q;
   state_t state_q, state_d;

   logic act1, act2, idle, conflict, fwd_hit, fwd_go, svc2;
   logic rd1_go, rd2_go, rd2_bank;

   logic [NUM_BANKS-1:0] b_en, b_we;
   logic [RW-1:0]        b_row   [NUM_BANKS];
   logic [WORD_W-1:0]    b_wdata [NUM_BANKS];
   logic [WORD_W-1:0]    b_rdata [NUM_BANKS];

   logic              rv1_q, rv2_q, rb1_q, rb2_q, fwd_sel_q;
   logic [WORD_W-1:0] fwd_data_q, hold1_q, hold2_q, data_out1, data_out2;
   logic [15:0]       cnt_q;

   assign req1 = '{addr: bus.mem_address1, wdata: bus.mem_data_in1,
                   we: bus.control_memwrite1, re: bus.control_memread1};
   assign req2 = '{addr: bus.mem_address2, wdata: bus.mem_data_in2,
                   we: bus.control_memwrite2, re: bus.control_memread2};

   assign act1 = req1.we | req1.re;
   assign act2 = req2.we | req2.re;
   assign idle = (state_q == IDLE);

`ifdef DMEM_FWD_EN
   assign fwd_hit = req1.we & req2.re & ~req2.we & (word_of(req1.addr) == word_of(req2.addr));
`else
   assign fwd_hit = 1'b0;
`endif

   assign fwd_go   = idle & act1 & fwd_hit;
   assign conflict = idle & act1 & act2 & (bank_of(req1.addr) == bank_of(req2.addr)) & ~fwd_hit;
   assign svc2     = idle & act2 & ~conflict & ~fwd_hit;

   // Slot 1 always owns its bank in IDLE; in REPLAY only the captured slot 2 request runs.
   always_comb begin
      b_en  = '0;
      b_we  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         b_row[b]   = '0;
         b_wdata[b] = '0;
         if (!idle) begin
            if (bank_of(rep_q.addr) == 1'(b)) begin
               b_en[b]    = 1'b1;
               b_we[b]    = rep_q.we;
               b_row[b]   = row_of(rep_q.addr);
               b_wdata[b] = rep_q.wdata;
            end
         end else if (act1 && bank_of(req1.addr) == 1'(b)) begin
            b_en[b]    = 1'b1;
            b_we[b]    = req1.we;
            b_row[b]   = row_of(req1.addr);
            b_wdata[b] = req1.wdata;
         end else if (svc2 && bank_of(req2.addr) == 1'(b)) begin
            b_en[b]    = 1'b1;
            b_we[b]    = req2.we;
            b_row[b]   = row_of(req2.addr);
            b_wdata[b] = req2.wdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (conflict) state_d = REPLAY;
         REPLAY:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rd1_go   = idle & req1.re & ~req1.we;
   assign rd2_go   = idle ? (svc2 & req2.re & ~req2.we) : (rep_q.re & ~rep_q.we);
   assign rd2_bank = idle ? bank_of(req2.addr) : bank_of(rep_q.addr);

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      dmem_bank #(.ROWS(ROWS)) u_bank (
         .clk   (CLOCK),
         .en    (b_en[g]),
         .we    (b_we[g]),
         .row   (b_row[g]),
         .wdata (b_wdata[g]),
         .rdata (b_rdata[g])
      );
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         rep_q      <= '0;
         cnt_q      <= '0;
         rv1_q      <= 1'b0;
         rv2_q      <= 1'b0;
         rb1_q      <= 1'b0;
         rb2_q      <= 1'b0;
         fwd_sel_q  <= 1'b0;
         fwd_data_q <= '0;
         hold1_q    <= '0;
         hold2_q    <= '0;
      end else begin
         state_q   <= state_d;
         rv1_q     <= rd1_go;
         rb1_q     <= bank_of(req1.addr);
         rv2_q     <= rd2_go | fwd_go;
         rb2_q     <= rd2_bank;
         fwd_sel_q <= fwd_go;
         hold1_q   <= data_out1;
         hold2_q   <= data_out2;
         if (fwd_go) fwd_data_q <= req1.wdata;
         if (conflict) begin
            rep_q <= req2;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   // Bank read data is already registered; the hold registers keep the last value between reads.
   assign data_out1 = rv1_q ? b_rdata[rb1_q] : hold1_q;
   assign data_out2 = rv2_q ? (fwd_sel_q ? fwd_data_q : b_rdata[rb2_q]) : hold2_q;

   assign bus.mem_data_out1 = data_out1;
   assign bus.mem_data_out2 = data_out2;
   assign bus.mem_rvalid1   = rv1_q;
   assign bus.mem_rvalid2   = rv2_q;
   assign bus.mem_stall     = conflict;
   assign bus.conflict_cnt  = cnt_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{req1.addr[WORD_W-1:AW+3], req1.addr[2:0],
                               req2.addr[WORD_W-1:AW+3], req2.addr[2:0],
                               rep_q.addr[WORD_W-1:AW+3], rep_q.addr[2:0]};

endmodule

// File: tb/tb_dual_port_dmem.sv
// tb/tb_dual_port_dmem.sv - Scoreboard bench for dual_port_dmem against a sequential memory model
module tb_dual_port_dmem;

   localparam int DEPTH = 256;
`ifdef DMEM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_if bus ();

   dual_port_dmem #(.DEPTH_WORDS(DEPTH)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [63:0] model [DEPTH];
   logic [63:0] exp1 [$];
   logic [63:0] exp2 [$];
   logic [15:0] exp_cnt = 16'd0;
   logic [63:0] last1 = 64'd0;
   logic [63:0] last2 = 64'd0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [63:0] a1, input logic [63:0] d1, input logic w1, input logic r1,
                        input logic [63:0] a2, input logic [63:0] d2, input logic w2, input logic r2);
      bus.mem_address1 = a1;  bus.mem_data_in1 = d1;
      bus.control_memwrite1 = w1;  bus.control_memread1 = r1;
      bus.mem_address2 = a2;  bus.mem_data_in2 = d2;
      bus.control_memwrite2 = w2;  bus.control_memread2 = r2;
   endtask

   // The model executes slot 1 then slot 2 as plain sequential memory operations.
   task automatic issue(input logic [63:0] a1, input logic [63:0] d1, input logic w1, input logic r1,
                        input logic [63:0] a2, input logic [63:0] d2, input logic w2, input logic r2);
      int  wi1  = int'((a1 >> 3) % DEPTH);
      int  wi2  = int'((a2 >> 3) % DEPTH);
      bit  fwd  = FWD && w1 && r2 && !w2 && (wi1 == wi2);
      bit  conf = (w1 || r1) && (w2 || r2) && ((wi1 % 2) == (wi2 % 2)) && !fwd;
      if (w1) model[wi1] = d1;
      else if (r1) exp1.push_back(model[wi1]);
      if (w2) model[wi2] = d2;
      else if (r2) exp2.push_back(model[wi2]);
      drive(a1, d1, w1, r1, a2, d2, w2, r2);
      @(negedge clk);
      check("stall", {63'd0, bus.mem_stall}, {63'd0, conf});
      check("conflict_cnt", {48'd0, bus.conflict_cnt}, {48'd0, exp_cnt});
      if (conf && exp_cnt != 16'hFFFF) exp_cnt++;
      @(posedge clk);
      if (conf) begin
         @(negedge clk);
         check("stall_replay", {63'd0, bus.mem_stall}, 64'd0);
         @(posedge clk);
      end
      #1;
      drive('0, '0, 0, 0, '0, '0, 0, 0);
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      a = 64'($urandom_range(0, 15)) << 3;
      a[2:0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a[63:11] = {$urandom, 21'($urandom)};
      return a;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         last1 = 64'd0;
         last2 = 64'd0;
      end else begin
         if (bus.mem_rvalid1) begin
            if (exp1.size() == 0) check("rvalid1_unexpected", 64'd1, 64'd0);
            else check("data_out1", bus.mem_data_out1, exp1.pop_front());
            last1 = bus.mem_data_out1;
         end else if (bus.mem_data_out1 !== last1) begin
            check("hold1", bus.mem_data_out1, last1);
         end
         if (bus.mem_rvalid2) begin
            if (exp2.size() == 0) check("rvalid2_unexpected", 64'd1, 64'd0);
            else check("data_out2", bus.mem_data_out2, exp2.pop_front());
            last2 = bus.mem_data_out2;
         end else if (bus.mem_data_out2 !== last2) begin
            check("hold2", bus.mem_data_out2, last2);
         end
      end
   end

   initial begin
      logic [63:0] a1, a2, d1, d2;
      logic        w1, r1, w2, r2;
      drive('0, '0, 0, 0, '0, '0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_data_out1", bus.mem_data_out1, 64'd0);
      check("rst_data_out2", bus.mem_data_out2, 64'd0);
      check("rst_rvalid", {62'd0, bus.mem_rvalid1, bus.mem_rvalid2}, 64'd0);
      check("rst_stall", {63'd0, bus.mem_stall}, 64'd0);
      check("rst_cnt", {48'd0, bus.conflict_cnt}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < DEPTH / 2; k++)
         issue(64'(16 * k), {$urandom, $urandom}, 1, 0, 64'(16 * k + 8), {$urandom, $urandom}, 1, 0);

      issue(64'h00, 64'hAAAA, 1, 0, 64'h08, 64'hBBBB, 1, 0);
      issue(64'h00, 64'h0, 0, 1, 64'h08, 64'h0, 0, 1);
      issue(64'h10, 64'h1, 1, 0, 64'h20, 64'h2, 1, 0);
      issue(64'h10, 64'h0, 0, 1, 64'h20, 64'h0, 0, 1);
      issue(64'h18, 64'h1111, 1, 0, 64'h18, 64'h2222, 1, 0);
      issue(64'h18, 64'h0, 0, 1, 64'h0, 64'h0, 0, 0);
      issue(64'h30, 64'hDEAD, 1, 0, 64'h30, 64'h0, 0, 1);
      issue(64'h800, 64'h77, 1, 0, 64'h0, 64'h0, 0, 0);
      issue(64'h0, 64'h0, 0, 0, 64'h000, 64'h0, 0, 1);

      issue(64'h40, 64'h0, 1, 0, 64'h0, 64'h0, 0, 0);
      drive(64'h50, 64'h0, 0, 1, 64'h40, 64'h5555, 1, 0);
      @(negedge clk);
      check("rst_replay_stall", {63'd0, bus.mem_stall}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive('0, '0, 0, 0, '0, '0, 0, 0);
      exp1.delete();
      exp2.delete();
      exp_cnt = 16'd0;
      #1;
      check("replay_rst_data_out", {bus.mem_data_out1 | bus.mem_data_out2}, 64'd0);
      check("replay_rst_flags", {61'd0, bus.mem_rvalid1, bus.mem_rvalid2, bus.mem_stall}, 64'd0);
      check("replay_rst_cnt", {48'd0, bus.conflict_cnt}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(64'h0, 64'h0, 0, 0, 64'h40, 64'h0, 0, 1);
      issue(64'h50, 64'h0, 0, 1, 64'h0, 64'h0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         a1 = rand_addr();  a2 = rand_addr();
         d1 = {$urandom, $urandom};  d2 = {$urandom, $urandom};
         {w1, r1} = 2'($urandom_range(0, 3));
         {w2, r2} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            a2 = a1;  w1 = 1;  w2 = 0;  r2 = 1;
         end
         issue(a1, d1, w1, r1, a2, d2, w2, r2);
      end

      repeat (5) @(posedge clk);
      #1;
      check("drain1", 64'(exp1.size()), 64'd0);
      check("drain2", 64'(exp2.size()), 64'd0);
      check("final_cnt", {48'd0, bus.conflict_cnt}, {48'd0, exp_cnt});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dual_port_dmem.md
# dual_port_dmem

Dual-ported, two-bank 64-bit data memory answering the load/store requests issued by both execution slots of the superscalar LEGv8 core in the same cycle. Word-interleaved banking lets two accesses to different banks complete in parallel. A same-bank collision services slot 1 immediately, replays slot 2 one cycle later, and raises a stall so the core holds its pipeline. Slot 1 is always the older instruction, and program order is preserved for same-address accesses.

## Interface
- DEPTH_WORDS, 256: total 64-bit words, power of two, ≥4; split evenly over 2 banks
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- mem_address1 / mem_address2  in  64  byte address, slot 1 / slot 2
- mem_data_in1 / mem_data_in2  in  64  store data, slot 1 / slot 2
- control_memwrite1 / control_memwrite2  in  1  store request
- control_memread1 / control_memread2  in  1  load request
- mem_data_out1 / mem_data_out2  out  64  load data, registered
- mem_rvalid1 / mem_rvalid2  out  1  one-cycle pulse: mem_data_outN updated
- mem_stall  out  1  core must hold both slots' inputs this cycle
- conflict_cnt  out  16  saturating count of bank conflicts

## Operation
- Address decode:
  - word index = addr[3 +: log2(DEPTH_WORDS)]
  - bank = addr[3]
  - row = addr[4 +: log2(DEPTH_WORDS)-1]
  - addr[2:0] and the upper bits are ignored, so addresses wrap modulo DEPTH_WORDS×8 bytes.
- A request is active when memwrite or memread is set. If both are set, it is treated as a write and no rvalid is produced.
- Conflict: both slots are active, in the same bank, and the block is in state IDLE.
- State machine:
  - IDLE, no conflict: service both slots. Stall = 0.
  - IDLE, conflict: service slot 1 and capture slot 2's request (addr, data, we, re) in the replay register. Assert stall combinationally. Go to REPLAY. Increment conflict_cnt; it saturates at 0xFFFF.
  - REPLAY: service only the captured slot 2 request. Ignore all port inputs; the core is presenting the same, held values. Stall = 0. Return to IDLE.
- Write/write to the same word: slot 1 commits in cycle N and slot 2 in N+1, so slot 2's data persists.
- Memory contents are not cleared by reset.
- mem_data_outN holds its last value between reads.

## Timing
- Load latency is 1 cycle: a read serviced in cycle N gives data and an rvalid pulse in N+1.
- A replayed slot 2 read returns in N+2.
- A store commits at the clock edge ending the cycle in which it is serviced.
- mem_stall is high for exactly one cycle per conflict and never in two consecutive cycles.
- Reset values: mem_data_out1/2 = 0, mem_rvalid1/2 = 0, mem_stall = 0, conflict_cnt = 0, state = IDLE.
- Reset asserted during REPLAY drops the captured request. A pending slot 2 store is lost and a pending load produces no rvalid.
- Bank accesses never cross: in any cycle, each bank performs at most one read or one write.

## Configuration
- DMEM_FWD_EN defined:
  - Case: slot 1 store and slot 2 load to the same word in the same cycle.
  - Result: no conflict, no stall, and conflict_cnt does not increment.
  - mem_data_out2 = mem_data_in1 in N+1, and the store commits in N.
- DMEM_FWD_EN undefined: the same case is an ordinary conflict. Slot 2 reads the newly stored value in N+2 through REPLAY.

## Structure
- Package dmem_pkg holds:
  - word width (64) and bank count (2)
  - packed request struct {addr, wdata, we, re}
  - state enum {IDLE, REPLAY}
- Sub-module dmem_bank is a single-port synchronous RAM with depth DEPTH_WORDS/2, 64-bit data, registered read and write-enable. It is instantiated twice.
- The top level contains the bank steering muxes, conflict detect, replay register, FSM, forwarding path and counter.

## Test plan
- Parallel stores then loads:
  - Cycle 1: slot 1 writes 0x00←0xAAAA and slot 2 writes 0x08←0xBBBB. Stall stays 0.
  - Then load 0x00 and 0x08 in the same cycle. Both rvalids pulse next cycle with 0xAAAA and 0xBBBB.
- Same-bank loads: 0x10 and 0x20 preloaded 0x1 and 0x2. Stall = 1 for one cycle; mem_data_out1 = 0x1 at N+1, mem_data_out2 = 0x2 at N+2, conflict_cnt = 1.
- Same-word stores: 0x18←0x1111 (slot 1) and 0x18←0x2222 (slot 2). A later load of 0x18 returns 0x2222.
- Store→load forward: slot 1 writes 0x30←0xDEAD and slot 2 loads 0x30.
  - With DMEM_FWD_EN: stall 0 and 0xDEAD at N+1.
  - Without: stall 1 and 0xDEAD at N+2.
- Reset mid-REPLAY:
  - Setup: 0x40 holds 0x0; slot 2 store 0x40←0x5555 conflicts with slot 1 load 0x50.
  - RESET is pulsed in the REPLAY cycle. All outputs go to 0 and the state returns to IDLE.
  - A later load of 0x40 returns 0x0.
- Wrap: DEPTH_WORDS = 256; store 0x800←0x77. A load of 0x000 returns 0x77.
